// File: rtl/led_scan_pkg.sv
// Shared types and counter-width helpers for the LED row-scan sequencer.
package led_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    WAIT_DISP,
    BLANK,
    LATCH
  } state_t;

  // Bit counter holds 0..num_bits-1; keep at least one bit for degenerate sizes.
  function automatic int unsigned bit_cnt_w(input int unsigned num_bits);
    return (num_bits > 1) ? $clog2(num_bits) : 1;
  endfunction

  // Display counter must be able to hold 0..cycles.
  function automatic int unsigned disp_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/led_disp_timer.sv
// Minimum on-time timer: counts displayed cycles after a latch, flags done.
module led_disp_timer
  import led_scan_pkg::*;
#(
  parameter int unsigned DISPLAY_CYCLES = 256
) (
  input  logic clk,
  input  logic n_rst,
  input  logic restart,
  input  logic count_en,
  input  logic force_done,
  output logic done
);

  localparam int unsigned   CntW    = disp_cnt_w(DISPLAY_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DISPLAY_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (restart) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (force_done) begin
      done_d = 1'b1;
    end else if (count_en && !done_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntLast) done_d = 1'b1;
    end
  end

  // Nothing is on screen out of reset, so the first row may latch at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row-scan sequencer: fetch a row, shift it out on sclk, blank, latch, advance.
module led_row_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int unsigned NUM_BITS       = 64,
  parameter int unsigned NUM_ROWS       = 16,
  parameter int unsigned ROW_W          = 4,
  parameter int unsigned DISPLAY_CYCLES = 256
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  output logic             fetch_req,
  output logic [ROW_W-1:0] fetch_row,
  input  logic             fetch_ack,
  output logic             load_enable,
  output logic             shift_enable,
  output logic             sclk,
  output logic             latch,
  output logic             oe_n,
  output logic [ROW_W-1:0] row_addr,
  output logic             frame_done
);

  localparam int unsigned        BitCntW = bit_cnt_w(NUM_BITS);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(NUM_BITS - 1);
  localparam logic [ROW_W-1:0]   RowLast = ROW_W'(NUM_ROWS - 1);

  state_t             state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ROW_W-1:0]   fetch_row_q, fetch_row_d;
  logic [ROW_W-1:0]   row_addr_q, row_addr_d;
  logic               shown_q, shown_d;
  logic               fetch_req_q, fetch_req_d;
  logic               shift_en_q, shift_en_d;
  logic               sclk_q, sclk_d;
  logic               latch_q, latch_d;
  logic               oe_n_q, oe_n_d;
  logic               frame_done_q, frame_done_d;
  logic               disp_done;
  logic               tmr_restart, tmr_count_en, tmr_force;

  assign load_enable = fetch_req_q & fetch_ack;

  // Next state plus the registered Moore outputs of that next state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    fetch_row_d  = fetch_row_q;
    row_addr_d   = row_addr_q;
    shown_d      = shown_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: if (enable) state_d = FETCH;
      FETCH: begin
        if (load_enable) begin
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
        if (bit_cnt_q == BitLast) state_d = disp_done ? BLANK : WAIT_DISP;
        else                      state_d = SHIFT_LO;
      end
      WAIT_DISP: if (disp_done) state_d = BLANK;
      BLANK: state_d = LATCH;
      LATCH: begin
        row_addr_d   = fetch_row_q;
        fetch_row_d  = (fetch_row_q == RowLast) ? '0 : fetch_row_q + ROW_W'(1);
        shown_d      = 1'b1;
        frame_done_d = (fetch_row_q == '0);
        state_d      = enable ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A row counts as on screen only once latched since the last IDLE.
    if (state_d == IDLE) shown_d = 1'b0;

    fetch_req_d = (state_d == FETCH);
    shift_en_d  = (state_d == SHIFT_HI);
    sclk_d      = (state_d == SHIFT_HI);
    latch_d     = (state_d == LATCH);
    oe_n_d      = (state_d inside {IDLE, BLANK, LATCH}) ? 1'b1 : ~shown_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      fetch_row_q  <= '0;
      row_addr_q   <= '0;
      shown_q      <= 1'b0;
      fetch_req_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      fetch_row_q  <= fetch_row_d;
      row_addr_q   <= row_addr_d;
      shown_q      <= shown_d;
      fetch_req_q  <= fetch_req_d;
      shift_en_q   <= shift_en_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tmr_restart  = (state_q == LATCH);
  assign tmr_count_en = ~oe_n_q;
  assign tmr_force    = (state_q == IDLE);

  led_disp_timer #(
    .DISPLAY_CYCLES(DISPLAY_CYCLES)
  ) u_disp_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .restart   (tmr_restart),
    .count_en  (tmr_count_en),
    .force_done(tmr_force),
    .done      (disp_done)
  );

  assign fetch_req    = fetch_req_q;
  assign fetch_row    = fetch_row_q;
  assign shift_enable = shift_en_q;
  assign sclk         = sclk_q;
  assign latch        = latch_q;
  assign oe_n         = oe_n_q;
  assign row_addr     = row_addr_q;
  assign frame_done   = frame_done_q;

endmodule
